pa_core_ifetch: RTL and testbench

- Instruction fetch unit. It consumes the PC from the core PC generator and issues word reads on the instruction bus.
- Fetched {pc, instruction} pairs are buffered in a small FIFO that feeds decode.
- It drives the PC generator's hold input, so the PC advances only when a fetch request is accepted.
- It discards in-flight and buffered instructions on jump or software reset.

---
 rtl/pa_core_ifetch.sv | 111 +++++++++++
 tb/tb_pa_core_ifetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pa_core_ifetch.sv
// rtl/pa_core_ifetch.sv - instruction fetch: one outstanding word read per PC, {pc, inst} FIFO to decode
module pa_core_ifetch #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          reset_flag_i,
  input  logic          jump_flag_i,
  input  logic [DW-1:0] pc_i,
  output logic          hold_flag_o,
  output logic          ibus_req_o,
  output logic [DW-1:0] ibus_addr_o,
  input  logic          ibus_gnt_i,
  input  logic          ibus_rvalid_i,
  input  logic [DW-1:0] ibus_rdata_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [DW-1:0] inst_pc_o,
  input  logic          inst_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_RESP, S_DROP} state_e;

  state_e        state_q;
  logic          run_q;
  logic [DW-1:0] pc_q;
  logic [DW-1:0] fifo_pc_q   [DEPTH];
  logic [DW-1:0] fifo_inst_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic flush, push, pop, full;

  assign flush = jump_flag_i | reset_flag_i;
  assign full  = (count_q == DEPTH_C);

  // run_q keeps the request low until the first clock after reset release
  assign ibus_req_o  = run_q & (state_q == S_REQ) & ~full & ~flush;
  assign ibus_addr_o = pc_i;
  assign hold_flag_o = ~(ibus_req_o & ibus_gnt_i);

  assign push = (state_q == S_RESP) & ibus_rvalid_i & ~flush;
  assign pop  = inst_valid_o & inst_ready_i & ~flush;

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = fifo_inst_q[rptr_q];
  assign inst_pc_o    = fifo_pc_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_REQ;
      run_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        S_REQ: begin
          if (ibus_req_o & ibus_gnt_i) begin
            pc_q    <= pc_i;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (ibus_rvalid_i)  state_q <= S_REQ;
          else if (flush)     state_q <= S_DROP;
        end
        S_DROP: begin
          if (ibus_rvalid_i)  state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_pc_q[wptr_q]   <= pc_q;
        fifo_inst_q[wptr_q] <= ibus_rdata_i;
        wptr_q              <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The request gating guarantees space for every response
  assert property (@(posedge clk_i) disable iff (!rst_n_i) push |-> !full);

endmodule

// File: tb/tb_pa_core_ifetch.sv
// tb/tb_pa_core_ifetch.sv - randomized and directed bench for pa_core_ifetch against a PC/bus/decode model
module tb_pa_core_ifetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        reset_flag_i, jump_flag_i;
  logic [31:0] pc_i;
  logic        hold_flag_o, ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o, inst_pc_o;
  logic        inst_ready_i;

  pa_core_ifetch #(.DW(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .reset_flag_i(reset_flag_i), .jump_flag_i(jump_flag_i),
    .pc_i(pc_i), .hold_flag_o(hold_flag_o), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: PC generator, bus slave, decode-visible instruction stream
  logic [31:0] pc_m;
  logic [31:0] q[$];
  logic [31:0] pop_log[$];
  logic        outst = 1'b0, drop = 1'b0;
  int          timer = 0;
  logic [31:0] out_addr = '0;

  int          gnt_mode = 0, rdy_mode = 0, lat_knob = 1, flush_on_resp = 0;
  logic        jump_pulse = 1'b0, reset_pulse = 1'b0, fired = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic rv, jf, rf, fl, req_e, acc, push_now;
    rv = outst && (timer <= 1);
    jf = jump_pulse;
    rf = reset_pulse;
    if (flush_on_resp != 0 && rv && q.size() == 1) begin
      if (flush_on_resp == 1) jf = 1'b1; else rf = 1'b1;
      flush_on_resp = 0;
      fired = 1'b1;
    end
    jump_flag_i   = jf;
    reset_flag_i  = rf;
    pc_i          = pc_m;
    ibus_rvalid_i = rv;
    ibus_rdata_i  = rv ? (32'h13 | out_addr) : $urandom;
    ibus_gnt_i    = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    inst_ready_i  = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    #1;
    fl    = jf | rf;
    req_e = !outst && !fl && (q.size() < DEPTH);
    chk("req", ibus_req_o, req_e);
    if (req_e) chk("addr", ibus_addr_o, pc_m);
    if (!fl) chk("hold", hold_flag_o, !(req_e && ibus_gnt_i));
    chk("valid", inst_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("inst_pc", inst_pc_o, q[0]);
      chk("inst", inst_o, 32'h13 | q[0]);
    end
    acc      = req_e && ibus_gnt_i;
    push_now = 1'b0;
    if (outst) begin
      if (rv) begin
        push_now = !fl && !drop;
        outst    = 1'b0;
      end else begin
        if (fl) drop = 1'b1;
        timer--;
      end
    end
    if (fl) q.delete();
    else begin
      if (inst_ready_i && q.size() != 0) pop_log.push_back(q.pop_front());
      if (push_now) q.push_back(out_addr);
    end
    if (acc) begin
      outst    = 1'b1;
      drop     = 1'b0;
      out_addr = pc_m;
      timer    = (lat_knob == 0) ? $urandom_range(1, 4) : lat_knob;
    end
    if (jf) pc_m = jump_target;
    else if (rf) pc_m = RESET_PC;
    else if (acc) pc_m = pc_m + 32'd4;
    jump_pulse  = 1'b0;
    reset_pulse = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic peek_req(input string tag, input logic exp_req, input logic [31:0] exp_addr);
    jump_flag_i  = 1'b0;
    reset_flag_i = 1'b0;
    pc_i         = pc_m;
    #1;
    chk({tag, "_req"}, ibus_req_o, exp_req);
    if (exp_req) chk({tag, "_addr"}, ibus_addr_o, exp_addr);
  endtask

  initial begin
    rst_n_i = 1'b0;
    reset_flag_i = 1'b0; jump_flag_i = 1'b0;
    pc_m = RESET_PC; pc_i = RESET_PC;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0; inst_ready_i = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      chk("rst_req", ibus_req_o, 1'b0);
      chk("rst_valid", inst_valid_o, 1'b0);
      chk("rst_hold", hold_flag_o, 1'b1);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_inst_pc", inst_pc_o, 32'h0);
    end
    rst_n_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);

    // Grant withheld after release
    gnt_mode = 0; rdy_mode = 1;
    run(3);
    peek_req("release", 1'b1, RESET_PC);
    chk("release_hold", hold_flag_o, 1'b1);

    // Streaming
    gnt_mode = 1; lat_knob = 1;
    run(8);
    chk("stream_cnt", pop_log.size() >= 3, 1'b1);
    if (pop_log.size() >= 3) begin
      chk("stream_pc0", pop_log[0], 32'h8000_0000);
      chk("stream_pc1", pop_log[1], 32'h8000_0004);
      chk("stream_pc2", pop_log[2], 32'h8000_0008);
    end

    // Backpressure: FIFO fills, PC must stall
    rdy_mode = 0;
    run(8);
    chk("bp_valid", inst_valid_o, 1'b1);
    peek_req("bp", 1'b0, 32'h0);
    chk("bp_hold", hold_flag_o, 1'b1);
    saved = ibus_addr_o;
    run(3);
    peek_req("bp2", 1'b0, 32'h0);
    chk("bp_pc_stable", ibus_addr_o, saved);
    rdy_mode = 1; gnt_mode = 0;
    run(1);
    peek_req("bp_release", 1'b1, saved);

    // Jump while a response is pending
    run(4);
    lat_knob = 3; gnt_mode = 1;
    run(1);
    gnt_mode = 0; jump_target = 32'h8000_0100; jump_pulse = 1'b1;
    run(1);
    run(4);
    chk("jw_valid", inst_valid_o, 1'b0);
    peek_req("jw", 1'b1, 32'h8000_0100);

    // Jump, then software reset, coincident with rvalid while one entry is buffered
    for (int k = 1; k <= 2; k++) begin
      rdy_mode = 1; gnt_mode = 0;
      run(4);
      rdy_mode = 0; gnt_mode = 1; lat_knob = 1;
      jump_target = 32'h8000_0200; flush_on_resp = k; fired = 1'b0;
      for (int i = 0; i < 20 && !fired; i++) cycle();
      chk("coinc_fired", fired, 1'b1);
      chk("coinc_valid", inst_valid_o, 1'b0);
      peek_req("coinc", 1'b1, (k == 1) ? 32'h8000_0200 : RESET_PC);
    end
    flush_on_resp = 0;

    // Randomized traffic with occasional redirects
    gnt_mode = 2; rdy_mode = 2; lat_knob = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        jump_pulse  = 1'b1;
        jump_target = 32'h8000_0000 | ($urandom_range(0, 255) << 2);
      end else if ($urandom_range(0, 39) == 0) begin
        reset_pulse = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
